// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer
//   In-order FIFO between the combinational ALU and the scoreboard writeback
//   port. ALU results are accepted over alu_valid_i/alu_ready_o and drained
//   over wb_valid_o/wb_ready_i, so a stalled writeback never loses a result.
//
// Ports
//   clk_i, rst_ni     clock (rising edge), synchronous active-low reset
//   flush_i           drop all buffered entries and the incoming result
//   alu_valid_i       ALU result present      alu_ready_o   buffer not full
//   alu_result_i      result                  alu_branch_res_i  branch outcome
//   alu_trans_id_i    producing instruction ID
//   wb_valid_o        head entry presented    wb_ready_i    head consumed
//   wb_result_o, wb_branch_res_o, wb_trans_id_o   head entry fields
//   count_o           number of stored entries
//
// Configuration
//   ALU_WB_BYPASS_EN  when defined, an empty buffer with a ready writeback
//                     forwards the ALU result combinationally (zero latency).
//                     When undefined, wb_* are driven from registers only.

module alu_wb_buffer #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]          result_q [DEPTH];
  logic [DEPTH-1:0]         branch_q;
  logic [TRANS_ID_BITS-1:0] id_q     [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic full;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign alu_ready_o = ~full;
  assign count_o     = count_q;

  // Pop only ever drains stored entries; a bypassed result never touches
  // the pointers or the count.
  assign pop = ~empty & wb_ready_i & ~flush_i;

`ifdef ALU_WB_BYPASS_EN
  logic bypass;

  assign bypass = empty & alu_valid_i & wb_ready_i & ~flush_i;
  assign push   = alu_valid_i & ~full & ~flush_i & ~bypass;

  assign wb_valid_o      = (~empty | bypass) & ~flush_i;
  assign wb_result_o     = bypass ? alu_result_i     : result_q[rd_ptr_q];
  assign wb_branch_res_o = bypass ? alu_branch_res_i : branch_q[rd_ptr_q];
  assign wb_trans_id_o   = bypass ? alu_trans_id_i   : id_q[rd_ptr_q];
`else
  assign push = alu_valid_i & ~full & ~flush_i;

  assign wb_valid_o      = ~empty & ~flush_i;
  assign wb_result_o     = result_q[rd_ptr_q];
  assign wb_branch_res_o = branch_q[rd_ptr_q];
  assign wb_trans_id_o   = id_q[rd_ptr_q];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      branch_q <= '0;
      // Storage is cleared too so wb_* reads back as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        id_q[i]     <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        result_q[wr_ptr_q] <= alu_result_i;
        branch_q[wr_ptr_q] <= alu_branch_res_i;
        id_q[wr_ptr_q]     <= alu_trans_id_i;
        wr_ptr_q           <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
module tb_alu_wb_buffer;

  localparam int XLEN  = 64;
  localparam int IDW   = 3;
  localparam int DEPTH = 4;
`ifdef ALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            alu_valid_i;
  logic            alu_ready_o;
  logic [XLEN-1:0] alu_result_i;
  logic            alu_branch_res_i;
  logic [IDW-1:0]  alu_trans_id_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [XLEN-1:0] wb_result_o;
  logic            wb_branch_res_o;
  logic [IDW-1:0]  wb_trans_id_o;
  logic [2:0]      count_o;

  alu_wb_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(IDW), .DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .alu_result_i     (alu_result_i),
    .alu_branch_res_i (alu_branch_res_i),
    .alu_trans_id_i   (alu_trans_id_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_branch_res_o  (wb_branch_res_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] result;
    logic            br;
    logic [IDW-1:0]  id;
  } entry_t;

  entry_t exp_q[$];
  int     occ;          // entries held by the reference FIFO before this cycle's push
  bit     mon_en = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the reference FIFO accepts whenever it is not full.
  task automatic cyc(input logic v, input logic [XLEN-1:0] d, input logic b,
                     input logic [IDW-1:0] id, input logic r, input logic f);
    entry_t e;
    @(negedge clk_i);
    alu_valid_i      = v;
    alu_result_i     = d;
    alu_branch_res_i = b;
    alu_trans_id_i   = id;
    wb_ready_i       = r;
    flush_i          = f;
    occ              = exp_q.size();
    if (v && !f && occ < DEPTH) begin
      e.result = d;
      e.br     = b;
      e.id     = id;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_rand(input logic [IDW-1:0] id, input logic r);
    cyc(1'b1, {$urandom, $urandom}, 1'($urandom), id, r, 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, r, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk_i);
    mon_en      = 1'b0;
    rst_ni      = 1'b0;
    alu_valid_i = 1'b0;
    wb_ready_i  = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_result", wb_result_o, 64'd0);
    chk("rst_wb_id", 64'(wb_trans_id_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
    exp_q.delete();
    occ    = 0;
    rst_ni = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares outputs against the reference FIFO every cycle and
  // retires the head whenever a handshake completes.
  initial begin
    entry_t h;
    bit     exp_v;
    forever begin
      @(negedge clk_i);
      #2;
      if (mon_en && rst_ni) begin
        exp_v = !flush_i && (occ != 0 || (BYP && alu_valid_i && wb_ready_i));
        chk("count", 64'(count_o), 64'(occ));
        chk("alu_ready", 64'(alu_ready_o), 64'(occ != DEPTH));
        chk("wb_valid", 64'(wb_valid_o), 64'(exp_v));
        if (exp_v) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
          end else begin
            h = exp_q[0];
            chk("wb_result", wb_result_o, h.result);
            chk("wb_branch", 64'(wb_branch_res_o), 64'(h.br));
            chk("wb_id", 64'(wb_trans_id_o), 64'(h.id));
            if (wb_ready_i) void'(exp_q.pop_front());
          end
        end
        if (flush_i) exp_q.delete();
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    alu_valid_i = 1'b0;
    alu_result_i = '0;
    alu_branch_res_i = 1'b0;
    alu_trans_id_i = '0;
    wb_ready_i = 1'b0;
    occ = 0;
    do_reset();

    // Basic transfer
    cyc(1'b1, 64'hDEAD_BEEF, 1'b1, 3'd3, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Fill beyond capacity, then drain in order
    for (int i = 0; i < 5; i++) push_rand(IDW'(i), 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Back-to-back with toggling ready across pointer wrap
    for (int i = 0; i < 10; i++) push_rand(IDW'(i), 1'(i % 2));
    idle(8, 1'b1);

    // Simultaneous push and pop at count 2
    push_rand(3'd1, 1'b0);
    push_rand(3'd2, 1'b0);
    push_rand(3'd3, 1'b1);
    idle(1, 1'b0);
    idle(4, 1'b1);

    // Flush with three entries stored and a result incoming
    for (int i = 0; i < 3; i++) push_rand(IDW'(4 + i), 1'b0);
    cyc(1'b1, 64'h1234, 1'b1, 3'd7, 1'b1, 1'b1);
    idle(1, 1'b1);
    push_rand(3'd0, 1'b1);
    idle(2, 1'b1);

    // Reset in the middle of operation
    for (int i = 0; i < 3; i++) push_rand(IDW'(i), 1'b0);
    do_reset();
    push_rand(3'd5, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom),
          IDW'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end
    idle(8, 1'b1);

    @(negedge clk_i);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
